// File: rtl/costas_pkg.sv
// Shared definitions for the Costas loop phase detector / PI loop filter:
// detector mode encodings and a signed saturate-to-N-bits helper.
package costas_pkg;

    typedef enum logic {
        MODE_BPSK = 1'b0,
        MODE_QPSK = 1'b1
    } costas_mode_e;

    // Clamp a signed value to the range of an n-bit two's complement number.
    function automatic logic signed [63:0] sat_n(input logic signed [63:0] x, input int n);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/costas_loop_filter_if.sv
// Sample input and feedback output bundle of the Costas loop filter.
// The master drives I/Q beats; the slave (the filter) returns NCO corrections.
interface costas_loop_filter_if #(
    parameter int DATA_WIDTH = 12,
    parameter int WIDTH      = 16
);
    logic                          mode;
    logic [2*DATA_WIDTH-1:0]       iq_tdata;
    logic                          iq_tvalid;
    logic signed [WIDTH-1:0]       feedback_tdata;
    logic                          feedback_tvalid;
    logic                          integ_sat;
    logic                          lock;

    modport master (
        output mode, iq_tdata, iq_tvalid,
        input  feedback_tdata, feedback_tvalid, integ_sat, lock
    );

    modport slave (
        input  mode, iq_tdata, iq_tvalid,
        output feedback_tdata, feedback_tvalid, integ_sat, lock
    );
endinterface

// File: rtl/costas_loop_filter_sat_add.sv
// Signed adder with clamp to OUT_W bits and a clip flag; purely combinational.
module sat_add
    import costas_pkg::*;
#(
    parameter int A_W   = 18,
    parameter int B_W   = 17,
    parameter int OUT_W = 18
) (
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [OUT_W-1:0] y,
    output logic                    clip
);
    localparam int SUM_W = ((A_W > B_W) ? A_W : B_W) + 1;

    logic signed [SUM_W-1:0] sum;
    logic signed [63:0]      wide;
    logic signed [63:0]      clamped;

    assign sum     = SUM_W'(a) + SUM_W'(b);
    assign wide    = 64'(sum);
    assign clamped = sat_n(wide, OUT_W);
    assign y       = clamped[OUT_W-1:0];
    assign clip    = (clamped != wide);
endmodule

// File: rtl/costas_loop_filter.sv
// Costas loop BPSK/QPSK phase detector, accumulate-and-dump and shift-based PI filter.
// Define COSTAS_LOCK_DETECT_EN to add the window-based lock indicator.
module costas_loop_filter
    import costas_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int WIDTH      = 16,
    parameter int ACC_WIDTH  = 18,
    parameter int DUMP_LEN   = 8,
    parameter int KP_SHIFT   = 2,
    parameter int KI_SHIFT   = 6
`ifdef COSTAS_LOCK_DETECT_EN
    ,
    parameter int LOCK_THRESH = 64,
    parameter int LOCK_COUNT  = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    costas_loop_filter_if.slave  bus
);
    localparam int E_W   = DATA_WIDTH + 2;
    localparam int CNT_W = $clog2(DUMP_LEN);
    localparam int D_W   = E_W + CNT_W;

    // Stage 1: phase detector, sign-extended before negation
    logic signed [DATA_WIDTH-1:0] s_i;
    logic signed [DATA_WIDTH-1:0] s_q;
    logic signed [E_W-1:0]        i_x;
    logic signed [E_W-1:0]        q_x;
    logic signed [E_W-1:0]        err_i;
    logic signed [E_W-1:0]        err_q;
    logic signed [E_W-1:0]        err_next;

    assign s_i      = bus.iq_tdata[DATA_WIDTH-1:0];
    assign s_q      = bus.iq_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign i_x      = E_W'(s_i);
    assign q_x      = E_W'(s_q);
    assign err_i    = s_i[DATA_WIDTH-1] ? -q_x : q_x;
    assign err_q    = s_q[DATA_WIDTH-1] ? -i_x : i_x;
    assign err_next = (bus.mode == MODE_QPSK) ? (err_i - err_q) : err_i;

    logic signed [E_W-1:0]       err_r;
    logic                        err_vld;
    logic signed [D_W-1:0]       acc;
    logic [CNT_W-1:0]            cnt;
    logic signed [D_W-1:0]       d;
    logic                        d_vld;
    logic signed [D_W-1:0]       p;
    logic signed [ACC_WIDTH-1:0] integ;
    logic                        integ_sat_r;
    logic                        s3_vld;
    logic signed [WIDTH-1:0]     fb;
    logic                        fb_vld;
    logic                        lock_r;

    logic signed [D_W-1:0]       err_ext;
    logic signed [D_W-1:0]       d_ki;
    logic signed [ACC_WIDTH-1:0] integ_next;
    logic                        integ_clip;
    logic signed [WIDTH-1:0]     fb_next;
    logic                        fb_clip;

    assign err_ext = D_W'(err_r);
    assign d_ki    = d >>> KI_SHIFT;

    sat_add #(.A_W(ACC_WIDTH), .B_W(D_W), .OUT_W(ACC_WIDTH)) u_integ_add (
        .a    (integ),
        .b    (d_ki),
        .y    (integ_next),
        .clip (integ_clip)
    );

    // Stage 4 sums the proportional term with the already-updated integrator
    sat_add #(.A_W(D_W), .B_W(ACC_WIDTH), .OUT_W(WIDTH)) u_fb_add (
        .a    (p),
        .b    (integ),
        .y    (fb_next),
        .clip (fb_clip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_r       <= '0;
            err_vld     <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            d           <= '0;
            d_vld       <= 1'b0;
            p           <= '0;
            integ       <= '0;
            integ_sat_r <= 1'b0;
            s3_vld      <= 1'b0;
            fb          <= '0;
            fb_vld      <= 1'b0;
        end else begin
            err_vld <= bus.iq_tvalid;
            if (bus.iq_tvalid) begin
                err_r <= err_next;
            end

            d_vld <= 1'b0;
            if (err_vld) begin
                if (cnt == CNT_W'(DUMP_LEN - 1)) begin
                    d     <= acc + err_ext;
                    acc   <= '0;
                    cnt   <= '0;
                    d_vld <= 1'b1;
                end else begin
                    acc <= acc + err_ext;
                    cnt <= cnt + CNT_W'(1);
                end
            end

            s3_vld <= d_vld;
            if (d_vld) begin
                p           <= d >>> KP_SHIFT;
                integ       <= integ_next;
                integ_sat_r <= integ_clip;
            end

            fb_vld <= s3_vld;
            if (s3_vld) begin
                fb <= fb_next;
            end
        end
    end

`ifdef COSTAS_LOCK_DETECT_EN
    localparam int LC_W = $clog2(LOCK_COUNT + 1);

    logic [LC_W-1:0] lock_cnt;
    logic [D_W:0]    d_abs;
    logic            qual;

    assign d_abs = d[D_W-1] ? -((D_W+1)'(d)) : (D_W+1)'(d);
    assign qual  = (d_abs < (D_W+1)'(LOCK_THRESH));

    // Count updates alongside the integrator; lock follows with the output pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt <= '0;
            lock_r   <= 1'b0;
        end else begin
            if (d_vld) begin
                if (!qual) begin
                    lock_cnt <= '0;
                end else if (lock_cnt != LC_W'(LOCK_COUNT)) begin
                    lock_cnt <= lock_cnt + LC_W'(1);
                end
            end
            if (s3_vld) begin
                lock_r <= (lock_cnt >= LC_W'(LOCK_COUNT));
            end
        end
    end
`else
    assign lock_r = 1'b0;
`endif

    assign bus.feedback_tdata  = fb;
    assign bus.feedback_tvalid = fb_vld;
    assign bus.integ_sat       = integ_sat_r;
    assign bus.lock            = lock_r;

    logic unused_ok;
    assign unused_ok = fb_clip;
endmodule
